// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus controller: FSM states, default latencies
// and the deterministic pattern returned for words that were never written.
package mem_bus_pkg;

  localparam int DEFAULT_READ_LATENCY  = 4;
  localparam int DEFAULT_WRITE_LATENCY = 3;
  localparam int CNT_W                 = $clog2(16);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DATA = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4
  } state_t;

  // Unwritten words read back as their own word-aligned byte address.
  function automatic logic [31:0] unwritten_word(input logic [31:2] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/mem_bus_store.sv
// Backing store: word array with one synchronous write port, one combinational
// read port and a per-word valid bit that is cleared by reset (the data is not).
module mem_bus_store #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_data,
  output logic                     rd_valid
);

  logic [31:0]      mem [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  assign rd_data  = mem[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/mem_bus_controller.sv
// Common-bus memory controller: latency-modelled reads and writes against an
// internal store, with snoop abort of pending reads.
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
  parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY,
  parameter int MEM_DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address_Com,
  input  logic [31:0] Data_Bus_Com_in,
  output logic [31:0] Data_Bus_Com_out,
  output logic        Data_Bus_Com_oe,
  input  logic        Mem_rd,
  input  logic        Mem_wr,
  input  logic        Mem_oprn_abort,
  output logic        Data_in_Bus,
  output logic        Mem_write_done,
  output logic        Mem_busy,
  output state_t      state_dbg
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:2]      addr_q, addr_n;
  logic [31:0]      wdata_q, wdata_n;
  logic [31:0]      rdata_q;
  logic             store_we;
  logic             capture;
  logic [31:0]      store_rd_data;
  logic             store_rd_valid;
  logic [31:0]      rd_word;

  mem_bus_store #(.DEPTH(MEM_DEPTH)) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (store_we),
    .wr_idx   (addr_q[AW+1:2]),
    .wr_data  (wdata_q),
    .rd_idx   (addr_q[AW+1:2]),
    .rd_data  (store_rd_data),
    .rd_valid (store_rd_valid)
  );

  assign rd_word = store_rd_valid ? store_rd_data : unwritten_word(addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      if (capture) rdata_q <= rd_word;
    end
  end

  // Abort and request-drop take priority over the counter reaching zero.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    store_we = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_wr) begin
          state_n = WR_WAIT;
          cnt_n   = WR_LOAD;
          addr_n  = Address_Com[31:2];
          wdata_n = Data_Bus_Com_in;
        end else if (Mem_rd && !Mem_oprn_abort) begin
          state_n = RD_WAIT;
          cnt_n   = RD_LOAD;
          addr_n  = Address_Com[31:2];
        end
      end
      RD_WAIT: begin
        if (Mem_oprn_abort || !Mem_rd) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = RD_DATA;
          capture = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RD_DATA: begin
        if (!Mem_rd || Mem_oprn_abort) state_n = IDLE;
      end
      WR_WAIT: begin
        if (cnt == '0) begin
          store_we = 1'b1;
          state_n  = WR_DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WR_DONE: begin
        if (!Mem_wr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign Data_in_Bus      = (state == RD_DATA);
  assign Data_Bus_Com_oe  = (state == RD_DATA);
  assign Mem_write_done   = (state == WR_DONE);
  assign Mem_busy         = (state != IDLE);
  assign Data_Bus_Com_out = rdata_q;
  assign state_dbg        = state;

endmodule
